// File: rtl/rh_cs1_pkg.sv
// RH11 CS1 shared definitions: field positions,
// devDATAI extraction helpers and interrupt FSM states.
package rh_cs1_pkg;

   localparam int bitSC   = 15;
   localparam int bitTRE  = 14;
   localparam int bitCPE  = 13;
   localparam int bitDVA  = 11;
   localparam int bitPSEL = 10;
   localparam int bitBAhi = 9;
   localparam int bitBAlo = 8;
   localparam int bitRDY  = 7;
   localparam int bitIE   = 6;
   localparam int bitFUNhi = 5;
   localparam int bitFUNlo = 1;
   localparam int bitGO   = 0;

   typedef enum logic {IDLE, PEND} intState_t;

   // devDATAI[20:35] is big-endian; bit 35 is CS1 bit 0.
   function automatic logic [15:0] cs1Word(input logic [0:15] lo);
      logic [15:0] w;
      for (int k = 0; k < 16; k++) w[k] = lo[15-k];
      return w;
   endfunction

   function automatic logic [4:0] cs1Fun(input logic [15:0] w);
      return w[bitFUNhi:bitFUNlo];
   endfunction

endpackage

// File: rtl/rh_drive_mux.sv
// Per-drive GO/DVA/FUN selection by unit number.
// Units with no attached drive read as all zero.
module rh_drive_mux
   import rh_cs1_pkg::*;
#(
   parameter int NUM_DRIVES = 8,
   parameter int UNIT_W     = 3
) (
   input  logic [UNIT_W-1:0]       unit,
   input  logic [NUM_DRIVES-1:0]   go,
   input  logic [NUM_DRIVES-1:0]   dva,
   input  logic [5*NUM_DRIVES-1:0] fun,
   output logic                    sGo,
   output logic                    sDva,
   output logic [4:0]              sFun
);

   // Select the addressed drive; no match leaves zeros.
   always_comb begin
      sGo  = 1'b0;
      sDva = 1'b0;
      sFun = 5'd0;
      for (int i = 0; i < NUM_DRIVES; i++) begin
         if (unit == UNIT_W'(i)) begin
            sGo  = go[i];
            sDva = dva[i];
            sFun = fun[5*i +: 5];
         end
      end
   end

endmodule

// File: rtl/rh_cs1_multi.sv
// Multi-drive RH11 CS1: drive mux, TRE edge capture,
// GO strobe with program-error check, interrupt FSM.
module rh_cs1_multi
   import rh_cs1_pkg::*;
#(
   parameter int NUM_DRIVES = 8,
   parameter int UNIT_W     = 3,
   parameter int NUM_ERR    = 9
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    devRESET,
   input  logic                    devLOBYTE,
   input  logic                    devHIBYTE,
   input  logic [0:35]             devDATAI,
   input  logic                    rhcs1WRITE,
   input  logic                    rhCLRGO,
   input  logic                    rhCLRTRE,
   input  logic                    rhCLR,
   input  logic                    rhIACK,
   input  logic [NUM_ERR-1:0]      errSTAT,
   input  logic [NUM_DRIVES-1:0]   rpATA,
   input  logic [NUM_DRIVES-1:0]   rpDVA,
   input  logic [NUM_DRIVES-1:0]   rpGO,
   input  logic [5*NUM_DRIVES-1:0] rpFUN,
   input  logic [UNIT_W-1:0]       rhUNIT,
   input  logic [17:16]            rhBA,
   output logic [15:0]             rhCS1,
   output logic                    rhINTR,
   output logic [NUM_DRIVES-1:0]   rhGOSTB,
   output logic [4:0]              rhFUNWR,
   output logic                    rhPGESET
);

   logic              sGo, sDva;
   logic [4:0]        sFun;
   logic [15:0]       cs;
   logic              rdy, sc, cpe, clr;
   logic              wrLo, wrHi, goWr, forceInt;
   logic              errAny, lastErr, errRise;
   logic              tre, psel, ie;
   logic              lastRdy, lastSc, rdyRise, scRise;
   logic [UNIT_W-1:0] lastUnit;
   logic [NUM_DRIVES-1:0] unitHot;
   intState_t         state;
   logic [19:0]       unusedHiData;

   rh_drive_mux #(
      .NUM_DRIVES(NUM_DRIVES),
      .UNIT_W(UNIT_W)
   ) uMux (
      .unit(rhUNIT),
      .go(rpGO),
      .dva(rpDVA),
      .fun(rpFUN),
      .sGo(sGo),
      .sDva(sDva),
      .sFun(sFun)
   );

   assign unusedHiData = devDATAI[0:19];
   assign cs       = cs1Word(devDATAI[20:35]);
   assign cpe      = 1'b0;
   assign rdy      = !sGo;
   assign sc       = tre | cpe | (|rpATA);
   assign clr      = devRESET | rhCLR;
   assign wrLo     = rhcs1WRITE & devLOBYTE;
   assign wrHi     = rhcs1WRITE & devHIBYTE;
   assign goWr     = wrLo & cs[bitGO];
   assign forceInt = wrLo & cs[bitIE] & !cs[bitGO] & rdy;
   assign errAny   = |errSTAT;
   assign errRise  = errAny & !lastErr;
   assign rdyRise  = rdy & !lastRdy & (rhUNIT == lastUnit);
   assign scRise   = sc & !lastSc;

   // One-hot decode of the selected unit for the GO strobe.
   always_comb begin
      unitHot = '0;
      for (int i = 0; i < NUM_DRIVES; i++)
         if (rhUNIT == UNIT_W'(i)) unitHot[i] = 1'b1;
   end

   // Assemble the CS1 read word.
   always_comb begin
      rhCS1                   = '0;
      rhCS1[bitSC]            = sc;
      rhCS1[bitTRE]           = tre;
      rhCS1[bitCPE]           = cpe;
      rhCS1[bitDVA]           = sDva;
      rhCS1[bitPSEL]          = psel;
      rhCS1[bitBAhi:bitBAlo]  = rhBA;
      rhCS1[bitRDY]           = rdy;
      rhCS1[bitIE]            = ie;
      rhCS1[bitFUNhi:bitFUNlo] = sFun;
      rhCS1[bitGO]            = sGo;
   end

   // Control bits and edge histories; clears win over sets.
   always_ff @(posedge clk) begin
      if (rst) begin
         tre      <= 1'b0;
         psel     <= 1'b0;
         ie       <= 1'b0;
         lastErr  <= 1'b0;
         lastRdy  <= 1'b0;
         lastSc   <= 1'b0;
         lastUnit <= '0;
      end else begin
         lastErr  <= errAny;
         lastRdy  <= rdy;
         lastSc   <= sc;
         lastUnit <= rhUNIT;
         if (clr | rhCLRTRE | rhCLRGO) tre <= 1'b0;
         else if (errRise)             tre <= 1'b1;
         if (clr)              psel <= 1'b0;
         else if (wrHi & rdy)  psel <= cs[bitPSEL];
         if (clr | rhIACK) ie <= 1'b0;
         else if (wrLo)    ie <= cs[bitIE];
      end
   end

   // GO strobe to a ready, available drive, else program error.
   always_ff @(posedge clk) begin
      if (rst) begin
         rhGOSTB  <= '0;
         rhFUNWR  <= 5'd0;
         rhPGESET <= 1'b0;
      end else begin
         rhGOSTB  <= '0;
         rhPGESET <= goWr & !rdy & !clr;
         if (goWr & rdy & sDva & !clr) begin
            rhGOSTB <= unitHot;
            rhFUNWR <= cs1Fun(cs);
         end
      end
   end

   // Interrupt request FSM; IACK and clears dominate triggers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rhINTR <= 1'b0;
      end else if (clr | rhIACK) begin
         state  <= IDLE;
         rhINTR <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if ((ie & (rdyRise | scRise)) | forceInt) begin
               state  <= PEND;
               rhINTR <= 1'b1;
            end
            PEND: if (wrLo & !cs[bitIE]) begin
               state  <= IDLE;
               rhINTR <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rh_cs1_multi.sv
// Directed vector bench for rh_cs1_multi
// (8 drives, 4-bit unit select to reach absent units).
module tb_rh_cs1_multi;

   typedef struct {
      logic [3:0]  unit;
      logic [7:0]  go, dva, ata;
      logic [8:0]  err;
      logic        wrLo, wrHi;
      logic [15:0] data;
      logic        iack, clrTre, clr;
      logic [15:0] eCs1;
      logic        eIntr;
      logic [7:0]  eGo;
      logic [4:0]  eFun;
      logic        ePge;
   } vec_t;

   logic clk = 1'b0, rst = 1'b1;
   logic devRESET = 0, devLOBYTE = 0, devHIBYTE = 0;
   logic [0:35] devDATAI = '0;
   logic rhcs1WRITE = 0, rhCLRGO = 0, rhCLRTRE = 0;
   logic rhCLR = 0, rhIACK = 0;
   logic [8:0]  errSTAT = '0;
   logic [7:0]  rpATA = '0, rpDVA = '0, rpGO = '0;
   logic [39:0] rpFUN = '0;
   logic [3:0]  rhUNIT = '0;
   logic [17:16] rhBA = '0;
   logic [15:0] rhCS1;
   logic        rhINTR, rhPGESET;
   logic [7:0]  rhGOSTB;
   logic [4:0]  rhFUNWR;

   int errors = 0, checks = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   rh_cs1_multi #(.NUM_DRIVES(8), .UNIT_W(4), .NUM_ERR(9)) dut (
      .clk(clk), .rst(rst), .devRESET(devRESET),
      .devLOBYTE(devLOBYTE), .devHIBYTE(devHIBYTE),
      .devDATAI(devDATAI), .rhcs1WRITE(rhcs1WRITE),
      .rhCLRGO(rhCLRGO), .rhCLRTRE(rhCLRTRE), .rhCLR(rhCLR),
      .rhIACK(rhIACK), .errSTAT(errSTAT), .rpATA(rpATA),
      .rpDVA(rpDVA), .rpGO(rpGO), .rpFUN(rpFUN),
      .rhUNIT(rhUNIT), .rhBA(rhBA), .rhCS1(rhCS1),
      .rhINTR(rhINTR), .rhGOSTB(rhGOSTB), .rhFUNWR(rhFUNWR),
      .rhPGESET(rhPGESET)
   );

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic putData(input logic [15:0] d);
      devDATAI[0:19] = 20'hABCDE;
      for (int k = 0; k < 16; k++) devDATAI[35-k] = d[k];
   endtask

   task automatic add(
      input logic [3:0] u, input logic [7:0] g, dv, at,
      input logic [8:0] er, input logic wl, wh,
      input logic [15:0] d, input logic ia, ct, cl,
      input logic [15:0] c, input logic it,
      input logic [7:0] gs, input logic [4:0] fn, input logic pg);
      vec_t v;
      v.unit = u; v.go = g; v.dva = dv; v.ata = at; v.err = er;
      v.wrLo = wl; v.wrHi = wh; v.data = d; v.iack = ia;
      v.clrTre = ct; v.clr = cl; v.eCs1 = c; v.eIntr = it;
      v.eGo = gs; v.eFun = fn; v.ePge = pg;
      vq.push_back(v);
   endtask

   initial begin
      // reset / basic select
      add(2,8'h00,8'h04,0,0,   0,0,16'h0000,0,0,0, 16'h0880,0,8'h00,5'h00,0);
      // GO write to unit 2
      add(2,8'h00,8'h04,0,0,   1,0,16'h0071,0,0,0, 16'h08C0,0,8'h04,5'h18,0);
      for (int i = 0; i < 5; i++)
         add(2,8'h04,8'h04,0,0, 0,0,16'h0000,0,0,0, 16'h0841,0,8'h00,5'h18,0);
      add(2,8'h00,8'h04,0,0,   0,0,16'h0000,0,0,0, 16'h08C0,1,8'h00,5'h18,0);
      add(2,8'h00,8'h04,0,0,   0,0,16'h0000,1,0,0, 16'h0880,0,8'h00,5'h18,0);
      add(2,8'h00,8'h04,0,0,   0,0,16'h0000,0,0,0, 16'h0880,0,8'h00,5'h18,0);
      // GO while busy: program error
      add(3,8'h08,8'h04,0,0,   0,0,16'h0000,0,0,0, 16'h0001,0,8'h00,5'h18,0);
      add(3,8'h08,8'h04,0,0,   1,0,16'h0001,0,0,0, 16'h0001,0,8'h00,5'h18,1);
      add(3,8'h08,8'h04,0,0,   0,0,16'h0000,0,0,0, 16'h0001,0,8'h00,5'h18,0);
      // TRE edge capture and clear
      add(3,8'h00,8'h04,0,0,   0,0,16'h0000,0,0,0, 16'h0080,0,8'h00,5'h18,0);
      add(3,8'h00,8'h04,0,9'h010,0,0,16'h0000,0,0,0, 16'hC080,0,8'h00,5'h18,0);
      add(3,8'h00,8'h04,0,0,   0,0,16'h0000,0,0,0, 16'hC080,0,8'h00,5'h18,0);
      add(3,8'h00,8'h04,0,9'h010,0,0,16'h0000,0,0,0, 16'hC080,0,8'h00,5'h18,0);
      add(3,8'h00,8'h04,0,9'h010,0,0,16'h0000,0,1,0, 16'h0080,0,8'h00,5'h18,0);
      add(3,8'h00,8'h04,0,9'h010,0,0,16'h0000,0,0,0, 16'h0080,0,8'h00,5'h18,0);
      add(3,8'h00,8'h04,0,0,   0,0,16'h0000,0,0,0, 16'h0080,0,8'h00,5'h18,0);
      // forced interrupt, then IACK racing an ATA rise
      add(3,8'h00,8'h04,0,0,   1,0,16'h0040,0,0,0, 16'h00C0,1,8'h00,5'h18,0);
      add(3,8'h00,8'h04,1,0,   0,0,16'h0000,1,0,0, 16'h8080,0,8'h00,5'h18,0);
      add(3,8'h00,8'h04,1,0,   0,0,16'h0000,0,0,0, 16'h8080,0,8'h00,5'h18,0);
      add(3,8'h00,8'h04,0,0,   0,0,16'h0000,0,0,0, 16'h0080,0,8'h00,5'h18,0);
      // unit switch must not look like an RDY rise
      add(0,8'h01,8'h04,0,0,   1,0,16'h0040,0,0,0, 16'h0041,0,8'h00,5'h18,0);
      add(0,8'h01,8'h04,0,0,   0,0,16'h0000,0,0,0, 16'h0041,0,8'h00,5'h18,0);
      add(1,8'h01,8'h04,0,0,   0,0,16'h0000,0,0,0, 16'h00C0,0,8'h00,5'h18,0);
      add(1,8'h01,8'h04,0,0,   0,0,16'h0000,0,0,0, 16'h00C0,0,8'h00,5'h18,0);
      // absent unit reads zero
      add(9,8'hFF,8'hFF,0,0,   0,0,16'h0000,0,0,0, 16'h00C0,0,8'h00,5'h18,0);
      add(9,8'hFF,8'hFF,0,0,   1,0,16'h0000,0,0,0, 16'h0080,0,8'h00,5'h18,0);
      // forced interrupt cancelled by write with IE=0
      add(9,8'hFF,8'hFF,0,0,   1,0,16'h0040,0,0,0, 16'h00C0,1,8'h00,5'h18,0);
      add(9,8'hFF,8'hFF,0,0,   1,0,16'h0000,0,0,0, 16'h0080,0,8'h00,5'h18,0);
      // PSEL write and controller clear
      add(9,8'hFF,8'hFF,0,0,   0,1,16'h0400,0,0,0, 16'h0480,0,8'h00,5'h18,0);
      add(9,8'hFF,8'hFF,0,0,   0,0,16'h0000,0,0,1, 16'h0080,0,8'h00,5'h18,0);
      // clear suppresses GO, then a clean GO, then no DVA
      add(2,8'h00,8'hFF,0,0,   1,0,16'h0003,0,0,1, 16'h0880,0,8'h00,5'h18,0);
      add(2,8'h00,8'hFF,0,0,   1,0,16'h0003,0,0,0, 16'h0880,0,8'h04,5'h01,0);
      add(2,8'h00,8'hFF,0,0,   0,0,16'h0000,0,0,0, 16'h0880,0,8'h00,5'h01,0);
      add(5,8'h00,8'h04,0,0,   1,0,16'h0001,0,0,0, 16'h0080,0,8'h00,5'h01,0);

      // reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cs1", 32'(rhCS1), 32'h0080);
      chk("rst_intr", 32'(rhINTR), 0);
      chk("rst_gostb", 32'(rhGOSTB), 0);
      chk("rst_pge", 32'(rhPGESET), 0);
      chk("rst_funwr", 32'(rhFUNWR), 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vq[i]) begin
         @(negedge clk);
         rhUNIT = vq[i].unit; rpGO = vq[i].go; rpDVA = vq[i].dva;
         rpATA = vq[i].ata; errSTAT = vq[i].err;
         rhcs1WRITE = vq[i].wrLo | vq[i].wrHi;
         devLOBYTE = vq[i].wrLo; devHIBYTE = vq[i].wrHi;
         putData(vq[i].data);
         rhIACK = vq[i].iack; rhCLRTRE = vq[i].clrTre;
         rhCLR = vq[i].clr;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_cs1", i), 32'(rhCS1), 32'(vq[i].eCs1));
         chk($sformatf("v%0d_intr", i), 32'(rhINTR), 32'(vq[i].eIntr));
         chk($sformatf("v%0d_gostb", i), 32'(rhGOSTB), 32'(vq[i].eGo));
         chk($sformatf("v%0d_funwr", i), 32'(rhFUNWR), 32'(vq[i].eFun));
         chk($sformatf("v%0d_pge", i), 32'(rhPGESET), 32'(vq[i].ePge));
      end

      // FUN mux and BA on unit 6, then GO to unit 6
      @(negedge clk);
      rhcs1WRITE = 0; devLOBYTE = 0; devHIBYTE = 0;
      rhIACK = 0; rhCLRTRE = 0; rhCLR = 0; errSTAT = 0; rpATA = 0;
      rhUNIT = 6; rpGO = 0; rpDVA = 8'hFF; rhBA = 2'b11;
      rpFUN[34:30] = 5'h1B;
      @(posedge clk); #1;
      chk("fun_ba_cs1", 32'(rhCS1), 32'h0BB6);
      @(negedge clk);
      rhcs1WRITE = 1; devLOBYTE = 1; putData(16'h0021);
      @(posedge clk); #1;
      chk("u6_gostb", 32'(rhGOSTB), 32'h40);
      chk("u6_funwr", 32'(rhFUNWR), 32'h10);
      @(negedge clk);
      rhcs1WRITE = 0; devLOBYTE = 0;
      @(posedge clk); #1;
      chk("u6_gostb_off", 32'(rhGOSTB), 0);

      // TRE from a high error bit, cleared by device reset
      @(negedge clk);
      rpFUN = '0; rhBA = 0; errSTAT = 9'h100;
      @(negedge clk);
      errSTAT = 0;
      @(posedge clk); #1;
      chk("tre_set", 32'(rhCS1[15:14]), 32'h3);
      @(negedge clk);
      devRESET = 1;
      @(posedge clk); #1;
      chk("tre_devreset", 32'(rhCS1[15:14]), 0);
      @(negedge clk);
      devRESET = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rh_cs1_multi.md
Name: rh_cs1_multi

Overview:
- Parametrised next-generation RH11 Control/Status Register 1 for a Massbus controller with NUM_DRIVES drives.
- Multiplexes per-drive FUN/GO/DVA by the selected unit and edge-detects a parametrised error vector into TRE.
- Adds what the single-drive CS1 lacks: a GO-write strobe with a program-error check, and an interrupt-request state machine with IACK handshake.
- Sits between the UBA device bus and the per-drive Massbus register files.

Parameters:
- NUM_DRIVES, 8, number of attached drives (1..8).
- UNIT_W, 3, width of the unit select, equal to clog2(NUM_DRIVES) with a minimum of 1.
- NUM_ERR, 9, number of controller error sources ORed into TRE.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- devRESET  in  1  UBA device reset.
- devLOBYTE  in  1  low-byte write enable.
- devHIBYTE  in  1  high-byte write enable.
- devDATAI  in  [0:35]  device data in, big-endian; bit 35 = CS1 bit 0.
- rhcs1WRITE  in  1  CS1 write cycle.
- rhCLRGO  in  1  GO clear.
- rhCLRTRE  in  1  transfer-error clear.
- rhCLR  in  1  controller clear.
- rhIACK  in  1  interrupt acknowledge.
- errSTAT  in  NUM_ERR  error status (DLT, WCE, UPE, NED, NEM, PGE, MXF, DPE, drive ERR, ...).
- rpATA  in  NUM_DRIVES  per-drive attention.
- rpDVA  in  NUM_DRIVES  per-drive drive available.
- rpGO  in  NUM_DRIVES  per-drive GO.
- rpFUN  in  5*NUM_DRIVES  per-drive function; drive n occupies bits [5n+4:5n].
- rhUNIT  in  UNIT_W  selected unit, from RHCS2.
- rhBA  in  [17:16]  bus address extension.
- rhCS1  out  16  CS1 read value.
- rhINTR  out  1  interrupt request.
- rhGOSTB  out  NUM_DRIVES  one-hot GO strobe to drives.
- rhFUNWR  out  5  function code accompanying rhGOSTB.
- rhPGESET  out  1  one-cycle request to set RHCS2[PGE].

Behaviour:
- All state updates on posedge clk. rst is synchronous and wins over everything.
- Reset values: rhINTR=0, rhGOSTB=0, rhFUNWR=0, rhPGESET=0, IE=0, PSEL=0, TRE=0, all edge-history registers 0.
- Selected-drive signals: sGO=rpGO[rhUNIT], sDVA=rpDVA[rhUNIT], sFUN=rpFUN slice for rhUNIT. A unit >= NUM_DRIVES reads as GO=0, DVA=0, FUN=0.
- RDY = !sGO.
- SC = TRE | CPE | (|rpATA). CPE is constant 0.
- TRE:
  - Set on the cycle after the rising edge of |errSTAT.
  - Cleared by devRESET, rhCLR, rhCLRTRE or rhCLRGO; clear wins over a simultaneous set.
- PSEL: loaded from CS1 bit 10 on rhcs1WRITE & devHIBYTE & RDY; cleared by devRESET or rhCLR.
- IE:
  - Loaded from CS1 bit 6 on rhcs1WRITE & devLOBYTE.
  - Cleared by devRESET, rhCLR or rhIACK; clear wins over a write.
- rhCS1 = {SC, TRE, CPE, 0, sDVA, PSEL, rhBA[17:16], RDY, IE, sFUN, sGO}. Combinational from state and inputs.
- GO write: rhcs1WRITE & devLOBYTE & bit0=1.
  - If RDY & sDVA: next cycle rhGOSTB[rhUNIT]=1 for exactly one cycle, with rhFUNWR = written bits 5:1.
  - If !RDY: next cycle rhPGESET=1 for one cycle and no strobe.
  - If RDY & !sDVA: no strobe and no PGE. NED is reported by RHCS2.
  - devRESET or rhCLR in the same cycle suppresses both strobe and PGE.
- Edge histories: lastRDY, lastSC and lastUNIT are registered every cycle.
  - rdyRise = RDY & !lastRDY & (rhUNIT==lastUNIT). Edge detection is suppressed on the cycle the unit select changes.
  - scRise = SC & !lastSC.
- Interrupt FSM, states IDLE and PEND:
  - IDLE->PEND when IE & (rdyRise | scRise).
  - IDLE->PEND on a low-byte write with bit6=1, bit0=0 and RDY=1 (software-forced interrupt).
  - PEND->IDLE on rhIACK, devRESET, rhCLR, or a low-byte write with bit6=0.
  - rhINTR=1 exactly in PEND. Trigger events occurring while in PEND are absorbed, not queued.
  - rhIACK in the same cycle as a trigger: IACK wins and the FSM ends in IDLE, because IE is cleared and gates the trigger.
- Latency:
  - CS1 write to rhCS1 field visible: 1 cycle.
  - Trigger to rhINTR: 1 cycle.
  - GO write to strobe: 1 cycle.
  - Error edge to TRE: 1 cycle.

Decomposition:
- Shared package rh_cs1_pkg holds:
  - bit-position constants: SC=15, TRE=14, CPE=13, DVA=11, PSEL=10, BA=9:8, RDY=7, IE=6, FUN=5:1, GO=0.
  - field extract functions for devDATAI.
  - interrupt-FSM state typedef {IDLE, PEND}.
- One sub-module, rh_drive_mux: parametrised selection of GO/DVA/FUN by rhUNIT, including the out-of-range-unit zero rule.
- Everything else is top level.

Test Plan:
- rst=1 for 2 cycles -> rhCS1=16'h0080 with rhBA=0 and all rpGO=0; rhINTR=0, rhGOSTB=0.
- Unit 2 DVA=1, write lobyte 16'h0071 (IE=1, FUN=5'h18, GO=1) -> next cycle rhGOSTB=8'h04 for 1 cycle, rhFUNWR=5'h18.
  - Then drive rpGO[2]=1 for 5 cycles and drop it -> rhINTR=1 one cycle after the drop.
  - Then rhIACK -> rhINTR=0 and IE=0.
- rpGO[3]=1, rhUNIT=3, write lobyte 16'h0001 -> rhPGESET pulses once and rhGOSTB stays 0.
- Pulse errSTAT[4] for 1 cycle -> rhCS1[15:14]=2'b11. Hold errSTAT[4]=1 and pulse rhCLRTRE -> TRE=0 and does not re-set while the bit stays high.
- IE=1, RDY=1, write lobyte 16'h0040 -> rhINTR=1.
  - Assert rhIACK and rpATA[0] rising in the same cycle -> rhINTR=0 next cycle and stays 0.
- rpGO[0]=1, rpGO[1]=0, IE=1; switch rhUNIT 0->1 -> no interrupt. Set rhUNIT=9 (UNIT_W=4, NUM_DRIVES=8) -> rhCS1[11]=0, [5:0]=0, RDY=1.
